// File: rtl/uart_rx.sv
// 8N1 UART receiver: LSB first, one start bit, eight data bits, one stop bit.
// Emits each good byte on out with a one-cycle valid; a bad stop bit gives frame_err instead.
module uart_rx #(
  parameter int CYCLES_PER_BIT = 10400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] out,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'(CYCLES_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    RECOVER,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t      state_reg, state_next;
  logic        s1_reg, rx_s_reg;
  logic [15:0] cnt_reg, cnt_next;
  logic [2:0]  idx_reg, idx_next;
  logic [7:0]  shift_reg, shift_next;
  logic [7:0]  out_reg, out_next;
  logic        valid_reg, valid_next;
  logic        frame_err_reg, frame_err_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= RECOVER;
      s1_reg        <= 1'b0;
      rx_s_reg      <= 1'b0;
      cnt_reg       <= '0;
      idx_reg       <= '0;
      shift_reg     <= '0;
      out_reg       <= '0;
      valid_reg     <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      s1_reg        <= rx;
      rx_s_reg      <= s1_reg;
      cnt_reg       <= cnt_next;
      idx_reg       <= idx_next;
      shift_reg     <= shift_next;
      out_reg       <= out_next;
      valid_reg     <= valid_next;
      frame_err_reg <= frame_err_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg + 16'd1;
    idx_next       = idx_reg;
    shift_next     = shift_reg;
    out_next       = out_reg;
    valid_next     = 1'b0;
    frame_err_next = 1'b0;
    case (state_reg)
      // A line held low through reset or a break must go high before any start is accepted.
      RECOVER: begin
        cnt_next = '0;
        if (rx_s_reg) state_next = IDLE;
      end
      IDLE: begin
        cnt_next = '0;
        if (!rx_s_reg) state_next = START;
      end
      START: begin
        if (cnt_reg == HALF_LAST) begin
          cnt_next = '0;
          if (!rx_s_reg) begin
            state_next = DATA;
            idx_next   = '0;
          end else begin
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next            = '0;
          shift_next[idx_reg] = rx_s_reg;
          if (idx_reg == 3'd7) state_next = STOP;
          else                 idx_next   = idx_reg + 3'd1;
        end
      end
      STOP: begin
        if (cnt_reg == BIT_LAST) begin
          cnt_next = '0;
          if (rx_s_reg) begin
            out_next   = shift_reg;
            valid_next = 1'b1;
            state_next = IDLE;
          end else begin
            frame_err_next = 1'b1;
            state_next     = RECOVER;
          end
        end
      end
      default: state_next = RECOVER;
    endcase
  end

  always_comb begin
    out       = out_reg;
    valid     = valid_reg;
    frame_err = frame_err_reg;
    busy      = (state_reg == START) || (state_reg == DATA) || (state_reg == STOP);
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx at 16 cycles per bit: a stimulus process queues expected
// strobes (kind, byte, cycle) and a monitor pops and compares whenever a strobe appears.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int HALF = CPB / 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic [7:0] out;
  logic       valid;
  logic       frame_err;
  logic       busy;

  uart_rx #(.CYCLES_PER_BIT(CPB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .out       (out),
    .valid     (valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         at;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] last_good = 8'h00;
  int         checks = 0;
  int         errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               name, act, act, req, req, cyc);
    end
  endtask

  // Expected strobe time follows from the latency rule: stop sample at E0+2+HALF+9*CPB.
  task automatic send_frame(input logic [7:0] b, input logic stop, input bit chk_busy);
    logic [9:0] bits;
    int         e0;
    exp_t       e;
    bits   = {stop, b, 1'b0};
    e0     = cyc + 1;
    e.err  = !stop;
    e.data = stop ? b : last_good;
    e.at   = e0 + 2 + HALF + 9 * CPB;
    if (stop) last_good = b;
    exp_q.push_back(e);
    for (int i = 0; i < 10; i++) begin
      rx = bits[i];
      for (int j = 0; j < CPB; j++) begin
        @(negedge clk);
        if (chk_busy && i == 0 && cyc == e0 + 1) check("busy_before_start", busy, 0);
        if (chk_busy && i == 0 && cyc == e0 + 2) check("busy_at_start", busy, 1);
      end
    end
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (valid || frame_err)) begin
      if (valid && frame_err) begin
        checks++;
        errors++;
        $display("FAIL both_strobes: valid=%0b frame_err=%0b required never both", valid, frame_err);
      end else if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: valid=%0b frame_err=%0b out=0x%0h, none required at cycle %0d",
                 valid, frame_err, out, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("strobe_kind_err", int'(frame_err), int'(e.err));
        check("strobe_out", int'(out), int'(e.data));
        check("strobe_cycle", cyc, e.at);
        check("busy_at_strobe", int'(busy), 0);
      end
    end
  end

  initial begin
    logic [7:0] rb;
    logic       rs;
    logic [7:0] abort_byte;
    int         e0;

    rst_n = 1'b0;
    rx    = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_out", out, 0);
    check("reset_valid", valid, 0);
    check("reset_frame_err", frame_err, 0);
    check("reset_busy", busy, 0);
    rst_n = 1'b1;
    idle(8);

    // Single frame with latency and busy timing.
    send_frame(8'hA5, 1'b1, 1'b1);
    idle(4);

    // Back-to-back frames, no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h5A, 1'b1, 1'b0);
    send_frame(8'h01, 1'b1, 1'b0);
    idle(4);

    // Bad stop bit, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(6);
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(4);

    // Short low glitch in IDLE.
    e0 = cyc + 1;
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    while (cyc < e0 + 12) begin
      @(negedge clk);
      if (cyc == e0 + 9)  check("glitch_busy_high", busy, 1);
      if (cyc == e0 + 10) check("glitch_busy_low", busy, 0);
    end
    send_frame(8'h81, 1'b1, 1'b0);
    idle(4);

    // Line held low through reset release.
    rx    = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    last_good = 8'h00;
    repeat (40) @(negedge clk);
    check("held_low_busy", busy, 0);
    check("held_low_out", out, 0);
    idle(8);
    send_frame(8'h7E, 1'b1, 1'b0);
    idle(4);

    // Reset in the middle of data bit 4.
    abort_byte = 8'h99;
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = abort_byte[i];
      repeat (CPB) @(negedge clk);
    end
    rx = abort_byte[4];
    repeat (HALF) @(negedge clk);
    rst_n = 1'b0;
    last_good = 8'h00;
    @(negedge clk);
    check("abort_out", out, 0);
    check("abort_busy", busy, 0);
    check("abort_valid", valid, 0);
    rx = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    idle(8);
    send_frame(8'h42, 1'b1, 1'b0);
    idle(4);

    // Randomized frames against the scoreboard.
    for (int n = 0; n < 16; n++) begin
      rb = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 5) != 0);
      send_frame(rb, rs, 1'b0);
      idle(rs ? $urandom_range(0, 5) : 4 + $urandom_range(0, 5));
    end

    begin
      int budget;
      budget = 0;
      while (exp_q.size() != 0 && budget < 500) begin
        @(negedge clk);
        budget++;
      end
      repeat (20) @(negedge clk);
      while (exp_q.size() != 0) begin
        exp_t e;
        e = exp_q.pop_front();
        checks++;
        errors++;
        $display("FAIL missing_strobe: no strobe observed, required err=%0b out=0x%0h at cycle %0d",
                 e.err, e.data, e.at);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
